nfc_sys_supervisor: RTL and testbench

//  Board-level supervisor between the clock generator and the UART-to-NFCA core. Qualifies PLL lock,

---
 rtl/nfc_sys_supervisor.sv | 179 +++++++++++++++++
 tb/tb_nfc_sys_supervisor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_sys_supervisor.sv
// Board supervisor: PLL-lock qualification, core reset sequencing, lock-loss count, status LEDs.
// Latency: pll_locked -> core_rstn rise = 2 sync + LOCK_FILTER + RST_HOLD_CYCLES cycles; LEDs 1 cycle.
// Backpressure: none; free-running, every input is sampled each cycle.
module nfc_sys_supervisor #(
  parameter int N_LED           = 3,
  parameter int LOCK_FILTER     = 16,
  parameter int RST_HOLD_CYCLES = 1024,
  parameter int STRETCH_CYCLES  = 4068000,
  parameter int BLINK_HALF      = 8136000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pll_locked,
  output logic               core_rstn,
  input  logic [N_LED-1:0]   status_in,
  input  logic [2*N_LED-1:0] led_mode,
  output logic [N_LED-1:0]   led,
  output logic               running,
  output logic [7:0]         lock_loss_cnt
);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_LOAD  = SW'(STRETCH_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_lk;
  logic [FW-1:0]   r_filt, w_filt_nxt;
  logic [HW-1:0]   r_hold, w_hold_nxt;
  logic [7:0]      r_loss, w_loss_nxt;
  logic            r_core_rstn, r_running;
  logic [N_LED-1:0]   r_prev, r_led, w_led_nxt;
  logic [2*N_LED-1:0] r_mode_q;
  logic            w_active;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_lk    <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_lk    <= r_sync1;
    end
  end

  // Sequencer state, counters and registered reset/running outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= WAIT_LOCK;
      r_filt      <= '0;
      r_hold      <= '0;
      r_loss      <= '0;
      r_core_rstn <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_filt      <= w_filt_nxt;
      r_hold      <= w_hold_nxt;
      r_loss      <= w_loss_nxt;
      r_core_rstn <= (w_state_nxt == RUN);
      r_running   <= (w_state_nxt == RUN);
    end
  end

  // Next state: filter consecutive lock, hold core in reset, count lock losses from RUN only.
  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = '0;
    w_hold_nxt  = '0;
    w_loss_nxt  = r_loss;
    case (r_state)
      WAIT_LOCK: begin
        if (r_lk) begin
          if (r_filt == FILT_LAST) w_state_nxt = HOLD;
          else                     w_filt_nxt  = r_filt + FW'(1);
        end
      end
      HOLD: begin
        if (!r_lk)                     w_state_nxt = WAIT_LOCK;
        else if (r_hold == HOLD_LAST)  w_state_nxt = RUN;
        else                           w_hold_nxt  = r_hold + HW'(1);
      end
      RUN: begin
        if (!r_lk) begin
          w_state_nxt = WAIT_LOCK;
          if (r_loss != 8'hFF) w_loss_nxt = r_loss + 8'd1;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // LEDs run only while RUN is held across the edge, so they clear on the same edge running drops.
  assign w_active = (r_state == RUN) && (w_state_nxt == RUN);

  // Previous-cycle status (edge detect) and mode copy (change detect); tracked even outside RUN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev   <= '0;
      r_mode_q <= '0;
      r_led    <= '0;
    end else begin
      r_prev   <= status_in;
      r_mode_q <= led_mode;
      r_led    <= w_led_nxt;
    end
  end

  for (genvar gi = 0; gi < N_LED; gi++) begin : g_ch
    logic [1:0]    w_mode;
    logic          w_chg, w_rise, w_led_ch;
    logic [SW-1:0] r_scnt, w_scnt_nxt;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic          r_bph, w_bph_nxt;

    assign w_mode = led_mode[2*gi +: 2];
    assign w_chg  = (w_mode != r_mode_q[2*gi +: 2]);
    assign w_rise = status_in[gi] & ~r_prev[gi];

    // Per-mode LED decode; counters of inactive modes and of a just-changed mode stay cleared.
    always_comb begin
      w_scnt_nxt = '0;
      w_bcnt_nxt = '0;
      w_bph_nxt  = 1'b0;
      w_led_ch   = 1'b0;
      if (w_active) begin
        case (w_mode)
          2'd0: w_led_ch = status_in[gi];
          2'd1: begin
            if (!w_chg) begin
              if (w_rise)              w_scnt_nxt = SCNT_LOAD;
              else if (r_scnt != '0)   w_scnt_nxt = r_scnt - SW'(1);
              w_led_ch = (w_scnt_nxt != '0);
            end
          end
          2'd2: begin
            if (!w_chg && status_in[gi]) begin
              w_led_ch = ~r_bph;
              if (r_bcnt == BLINK_LAST) begin
                w_bph_nxt = ~r_bph;
              end else begin
                w_bcnt_nxt = r_bcnt + BW'(1);
                w_bph_nxt  = r_bph;
              end
            end
          end
          default: w_led_ch = ~status_in[gi];
        endcase
      end
    end

    // Stretch and blink counters.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_scnt <= '0;
        r_bcnt <= '0;
        r_bph  <= 1'b0;
      end else begin
        r_scnt <= w_scnt_nxt;
        r_bcnt <= w_bcnt_nxt;
        r_bph  <= w_bph_nxt;
      end
    end

    assign w_led_nxt[gi] = w_led_ch;
  end

  assign core_rstn     = r_core_rstn;
  assign running       = r_running;
  assign lock_loss_cnt = r_loss;
  assign led           = r_led;
endmodule

// File: tb/tb_nfc_sys_supervisor.sv
// Scoreboard bench for nfc_sys_supervisor with a behavioural reference model.
// Model pushes expected outputs per clock edge; a negedge monitor pops and compares.
// Async reset and latency milestones are checked directly by the driver.
module tb_nfc_sys_supervisor;
  localparam int NL = 3, LF = 4, RH = 8, SC = 10, BH = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic            pll_locked = 1'b0;
  logic            core_rstn;
  logic [NL-1:0]   status_in = '0;
  logic [2*NL-1:0] led_mode = '0;
  logic [NL-1:0]   led;
  logic            running;
  logic [7:0]      lock_loss_cnt;

  always #5 clk = ~clk;

  nfc_sys_supervisor #(
    .N_LED(NL), .LOCK_FILTER(LF), .RST_HOLD_CYCLES(RH),
    .STRETCH_CYCLES(SC), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rstn(rstn), .pll_locked(pll_locked), .core_rstn(core_rstn),
    .status_in(status_in), .led_mode(led_mode), .led(led),
    .running(running), .lock_loss_cnt(lock_loss_cnt)
  );

  typedef struct packed {
    logic          core_rstn;
    logic          running;
    logic [7:0]    loss;
    logic [NL-1:0] led;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model state: lock is "running" once the last LF+RH synchronised samples were all 1.
  int cyc, consec, loss;
  bit p1, p2, run;
  bit prev_s[NL];
  int prev_mode[NL];
  int last_rise[NL];
  int bstart[NL];

  task automatic model_reset();
    cyc = 0; consec = 0; loss = 0; p1 = 0; p2 = 0; run = 0;
    for (int i = 0; i < NL; i++) begin
      prev_s[i] = 0; prev_mode[i] = 0; last_rise[i] = -1; bstart[i] = -1;
    end
  endtask

  task automatic model_edge();
    bit lk, run_before, active, s, chg, l;
    int m;
    exp_t e;
    lk = p2; p2 = p1; p1 = pll_locked;
    run_before = run;
    if (lk) begin
      consec++;
      if (consec > LF + RH) consec = LF + RH;
    end else begin
      if (run && loss < 255) loss++;
      consec = 0;
    end
    run = (consec >= LF + RH);
    active = run_before && run;
    e.led = '0;
    for (int i = 0; i < NL; i++) begin
      s = status_in[i];
      m = int'(led_mode[2*i +: 2]);
      chg = (m != prev_mode[i]);
      if (active && m == 1 && !chg) begin
        if (s && !prev_s[i]) last_rise[i] = cyc;
      end else begin
        last_rise[i] = -1;
      end
      if (active && m == 2 && !chg && s) begin
        if (bstart[i] < 0) bstart[i] = cyc;
      end else begin
        bstart[i] = -1;
      end
      l = 0;
      if (active) begin
        case (m)
          0: l = s;
          1: l = (last_rise[i] >= 0) && (cyc - last_rise[i] < SC);
          2: l = (bstart[i] >= 0) && (((cyc - bstart[i]) / BH) % 2 == 0);
          default: l = !s;
        endcase
      end
      e.led[i] = l;
      prev_s[i] = s;
      prev_mode[i] = m;
    end
    cyc++;
    e.core_rstn = run;
    e.running   = run;
    e.loss      = 8'(loss);
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the expected entry for the last edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("core_rstn", int'(core_rstn), int'(e.core_rstn));
      check("running", int'(running), int'(e.running));
      check("lock_loss_cnt", int'(lock_loss_cnt), int'(e.loss));
      check("led", int'(led), int'(e.led));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_run(output int k);
    k = 0;
    while (!core_rstn && k < 200) begin
      tick();
      k++;
    end
  endtask

  task automatic check_window(input string name, input int act, input int req);
    checks++;
    if (act < req - 1 || act > req + 1) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d+-1", name, act, req);
    end
  endtask

  // Async reset applied between edges; outputs must clear without a clock.
  task automatic apply_reset();
    #2 rstn = 1'b0;
    #1;
    check("async_core_rstn", int'(core_rstn), 0);
    check("async_running", int'(running), 0);
    check("async_loss", int'(lock_loss_cnt), 0);
    check("async_led", int'(led), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, ones, drop_left;
    logic [11:0] pat;
    model_reset();
    rstn = 1'b0;
    #3;
    check("reset_core_rstn", int'(core_rstn), 0);
    check("reset_running", int'(running), 0);
    check("reset_loss", int'(lock_loss_cnt), 0);
    check("reset_led", int'(led), 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // 1: clean lock
    pll_locked = 1'b1;
    wait_run(k);
    check_window("lock_latency", k, 14);
    check("lock_loss_after_lock", int'(lock_loss_cnt), 0);

    // 2: glitchy lock restarts the filter
    apply_reset();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1; for (int i = 0; i < 3; i++) tick();
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1;
    wait_run(k);
    check_window("glitch_lock_latency", k + 4, 18);
    check("glitch_loss", int'(lock_loss_cnt), 0);

    // 3: lock loss in RUN, resequence, saturation
    for (int it = 0; it < 300; it++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      d = 1;
      while (core_rstn && d < 10) begin tick(); d++; end
      if (it == 0) begin
        checks++;
        if (d > 3) begin
          errors++;
          $display("FAIL drop_latency actual=%0d required<=3", d);
        end
      end
      wait_run(k);
      if (it == 0) begin
        check_window("relock_latency", k, 12);
        check("loss_first", int'(lock_loss_cnt), 1);
      end
    end
    check("loss_saturated", int'(lock_loss_cnt), 255);

    // 4: stretch with retrigger on ch1, blink on ch2
    led_mode = 6'b10_01_00;
    status_in = '0;
    tick(); tick();
    status_in = 3'b110;
    ones = 0; pat = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ones += int'(led[1]);
      if (i < 12) pat[11-i] = led[2];
      status_in[1] = (i == 5);
    end
    check("stretch_ontime", ones, 16);
    check("blink_pattern", int'(pat), int'(12'b111000111000));
    status_in[2] = 1'b0;
    tick();
    check("blink_drop", int'(led[2]), 0);

    // 5: random status/modes with occasional lock loss
    drop_left = 0;
    for (int i = 0; i < 400; i++) begin
      status_in = NL'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        led_mode = 6'($urandom_range(0, 63));
        led_mode[1:0] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
      end
      if (drop_left > 0) drop_left--;
      else if ($urandom_range(0, 59) == 0) drop_left = int'($urandom_range(1, 5));
      pll_locked = (drop_left == 0);
      tick();
    end

    // 6: reset mid-HOLD, then mid-stretch
    pll_locked = 1'b1;
    apply_reset();
    for (int i = 0; i < 8; i++) tick();
    apply_reset();
    wait_run(k);
    check_window("relock_after_reset", k, 14);
    led_mode = 6'b00_01_00;
    status_in = '0;
    tick(); tick();
    status_in[1] = 1'b1;
    tick();
    status_in[1] = 1'b0;
    tick(); tick();
    apply_reset();
    for (int i = 0; i < 5; i++) tick();

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
